// File: rtl/pc_pred_pkg.sv
// Shared encodings and the 2-bit saturating counter step for the fetch-stage PC predictor.
package pc_pred_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_REPAIR = 2'b01,
        PCSRC_ERET   = 2'b10,
        PCSRC_EXC    = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic ctr_e sat_ctr_next(input ctr_e ctr, input logic taken);
        ctr_e nxt;
        nxt = ctr;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_pred_btb.sv
// Direct-mapped BTB: valid/tag/target/counter arrays, one combinational read port,
// one synchronous update port and an invalidate port. Addresses are word addresses.
module pc_pred_btb
    import pc_pred_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:2] i_rd_pc,
    output logic             o_rd_taken,
    output logic [WIDTH-1:0] o_rd_target,
    input  logic             i_upd_en,
    input  logic [WIDTH-1:2] i_upd_pc,
    input  logic             i_upd_taken,
    input  logic [WIDTH-1:0] i_upd_target,
    input  logic             i_inv_en,
    input  logic [WIDTH-1:2] i_inv_pc
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WIDTH-1:0]     target_q [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx, upd_idx, inv_idx;
    logic [TAG_W-1:0] rd_tag, upd_tag;
    logic             rd_hit, upd_hit;

    assign rd_idx  = i_rd_pc[IDX_W+1:2];
    assign rd_tag  = i_rd_pc[WIDTH-1:IDX_W+2];
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[WIDTH-1:IDX_W+2];
    assign inv_idx = i_inv_pc[IDX_W+1:2];

    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign o_rd_taken  = rd_hit && ctr_q[rd_idx][1];
    assign o_rd_target = target_q[rd_idx];

    // Reads are taken from the current arrays, so a same-index update is seen next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            if (i_upd_en) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= sat_ctr_next(ctr_q[upd_idx], i_upd_taken);
                    if (i_upd_taken) begin
                        target_q[upd_idx] <= i_upd_target;
                    end
                end else if (i_upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= i_upd_target;
                    ctr_q[upd_idx]    <= CTR_WT;
                end
            end
            if (i_inv_en) begin
                valid_q[inv_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_pred_unit.sv
// Fetch-stage next-PC generator: PC register, BTB prediction, EX repair, exception/ERET redirect.
// Optional statistics counters are built when PC_PRED_STATS_EN is defined.
module pc_pred_unit
    import pc_pred_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      ENTRIES    = 16,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_pred_taken,
    output logic [WIDTH-1:0] o_pred_target,
    input  logic             i_res_valid,
    input  logic             i_res_is_br,
    input  logic [WIDTH-1:0] i_res_pc,
    input  logic             i_res_taken,
    input  logic [WIDTH-1:0] i_res_target,
    input  logic             i_res_pred_taken,
    input  logic [WIDTH-1:0] i_res_pred_target,
    input  logic             i_exception,
    input  logic             i_eret,
    input  logic [WIDTH-1:0] i_epc,
    output logic             o_flush,
    output logic [1:0]       o_pcsrc
`ifdef PC_PRED_STATS_EN
    ,
    output logic [31:0]      o_stat_lookups,
    output logic [31:0]      o_stat_mispred
`endif
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             btb_taken;
    logic [WIDTH-1:0] btb_target;
    logic             mispred;
    pcsrc_e           pcsrc;

    pc_pred_btb #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES)
    ) u_btb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rd_pc      (pc_q[WIDTH-1:2]),
        .o_rd_taken   (btb_taken),
        .o_rd_target  (btb_target),
        .i_upd_en     (i_res_valid & i_res_is_br),
        .i_upd_pc     (i_res_pc[WIDTH-1:2]),
        .i_upd_taken  (i_res_taken),
        .i_upd_target (i_res_target),
        .i_inv_en     (i_res_valid & ~i_res_is_br & i_res_pred_taken),
        .i_inv_pc     (i_res_pc[WIDTH-1:2])
    );

    assign o_pc          = pc_q;
    assign o_pred_taken  = btb_taken;
    assign o_pred_target = btb_taken ? btb_target : '0;

    // An aliased non-branch (taken=0, pred_taken=1) falls out of this as a repair to pc+4.
    assign mispred = i_res_valid &
                     ((i_res_taken != i_res_pred_taken) |
                      (i_res_taken & (i_res_target != i_res_pred_target)));

    always_comb begin
        pc_d    = pc_q;
        pcsrc   = PCSRC_SEQ;
        o_flush = 1'b0;
        if (i_eret) begin
            pc_d  = i_epc;
            pcsrc = PCSRC_ERET;
        end else if (i_exception) begin
            pc_d  = EXC_VECTOR;
            pcsrc = PCSRC_EXC;
        end else if (mispred) begin
            pc_d    = i_res_taken ? i_res_target : (i_res_pc + PC_STEP);
            pcsrc   = PCSRC_REPAIR;
            o_flush = 1'b1;
        end else if (i_stall) begin
            pc_d = pc_q;
        end else if (btb_taken) begin
            pc_d = btb_target;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    assign o_pcsrc = pcsrc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_PRED_STATS_EN
    logic [31:0] lookups_q, mispred_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lookups_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (!i_stall) lookups_q <= lookups_q + 32'd1;
            if (mispred)  mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign o_stat_lookups = lookups_q;
    assign o_stat_mispred = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_pc_pred_unit.sv
// Directed, table-driven bench for pc_pred_unit plus a hand-written async reset sequence.
module tb_pc_pred_unit;

    typedef struct {
        logic        stall, rv, rbr;
        logic [31:0] rpc;
        logic        rtk;
        logic [31:0] rtgt;
        logic        rptk;
        logic [31:0] rptgt;
        logic        exc, eret;
        logic [31:0] epc;
        logic [31:0] e_pc;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_flush;
        logic [1:0]  e_src;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, rv = 1'b0, rbr = 1'b0, rtk = 1'b0, rptk = 1'b0;
    logic        exc = 1'b0, eret = 1'b0;
    logic [31:0] rpc = '0, rtgt = '0, rptgt = '0, epc = '0;
    logic [31:0] pc, ptgt;
    logic        ptk, flush;
    logic [1:0]  src;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_pred_unit #(
        .WIDTH      (32),
        .ENTRIES    (16),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h8000_0180)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall           (stall),
        .o_pc              (pc),
        .o_pred_taken      (ptk),
        .o_pred_target     (ptgt),
        .i_res_valid       (rv),
        .i_res_is_br       (rbr),
        .i_res_pc          (rpc),
        .i_res_taken       (rtk),
        .i_res_target      (rtgt),
        .i_res_pred_taken  (rptk),
        .i_res_pred_target (rptgt),
        .i_exception       (exc),
        .i_eret            (eret),
        .i_epc             (epc),
        .o_flush           (flush),
        .o_pcsrc           (src)
    );

    function automatic vec_t mk(
        input logic s, input logic v, input logic b, input logic [31:0] p, input logic t,
        input logic [31:0] tg, input logic pt, input logic [31:0] ptg, input logic x,
        input logic er, input logic [31:0] ep, input logic [31:0] xpc, input logic xptk,
        input logic [31:0] xptgt, input logic xfl, input logic [1:0] xsrc);
        vec_t r;
        r.stall = s;  r.rv = v;  r.rbr = b;  r.rpc = p;  r.rtk = t;  r.rtgt = tg;
        r.rptk = pt;  r.rptgt = ptg;  r.exc = x;  r.eret = er;  r.epc = ep;
        r.e_pc = xpc;  r.e_ptk = xptk;  r.e_ptgt = xptgt;  r.e_flush = xfl;  r.e_src = xsrc;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; rv = 0; rbr = 0; rpc = '0; rtk = 0; rtgt = '0; rptk = 0; rptgt = '0;
        exc = 0; eret = 0; epc = '0;
    endtask

    initial begin
        //           st rv br rpc          tk rtgt         ptk rptgt        ex er epc            exp_pc        ptk ptgt        fl src
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h0,        0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h4,        0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h8,        0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'hC,        0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,1,1,32'h10,      1,32'h40,      0,32'h0,       0,0,32'h0,        32'h10,       0,32'h0,      1,2'b01));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h10,       32'h40,       0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h10,       1,32'h40,     0,2'b00));
        vecs.push_back(mk(0,1,1,32'h10,      0,32'h0,       1,32'h40,      0,0,32'h0,        32'h40,       0,32'h0,      1,2'b01));
        vecs.push_back(mk(0,1,1,32'h10,      0,32'h0,       0,32'h0,       0,0,32'h0,        32'h14,       0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h10,       32'h18,       0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h10,       0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,1,1,32'h20,      1,32'h80,      0,32'h0,       1,1,32'h200,      32'h14,       0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h200,      0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       1,0,32'h0,        32'h204,      0,32'h0,      0,2'b11));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h80000180, 0,32'h0,      0,2'b00));
        vecs.push_back(mk(1,1,1,32'h30,      1,32'h100,     1,32'h104,     0,0,32'h0,        32'h80000184, 0,32'h0,      1,2'b01));
        vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h100,      0,32'h0,      0,2'b00));
        vecs.push_back(mk(1,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h100,      0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h30,       32'h100,      0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,1,1,32'h30,      1,32'h300,     1,32'h300,     0,0,32'h0,        32'h30,       1,32'h100,    0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h30,       32'h100,      0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h30,       1,32'h300,    0,2'b00));
        vecs.push_back(mk(0,1,0,32'h30,      0,32'h0,       1,32'h300,     0,0,32'h0,        32'h300,      0,32'h0,      1,2'b01));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h30,       32'h34,       0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h30,       0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'hFFFFFFFC, 32'h34,       0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'hFFFFFFFC, 0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h0,        0,32'h0,      0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,1,32'h20,       32'h4,        0,32'h0,      0,2'b10));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h20,       1,32'h80,     0,2'b00));
        vecs.push_back(mk(0,0,0,32'h0,       0,32'h0,       0,32'h0,       0,0,32'h0,        32'h80,       0,32'h0,      0,2'b00));

        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall; rv = vecs[i].rv; rbr = vecs[i].rbr; rpc = vecs[i].rpc;
            rtk = vecs[i].rtk; rtgt = vecs[i].rtgt; rptk = vecs[i].rptk; rptgt = vecs[i].rptgt;
            exc = vecs[i].exc; eret = vecs[i].eret; epc = vecs[i].epc;
            #1;
            n_vec++;
            chk("pc",          i, pc,             vecs[i].e_pc);
            chk("pred_taken",  i, {31'b0, ptk},   {31'b0, vecs[i].e_ptk});
            chk("pred_target", i, ptgt,           vecs[i].e_ptgt);
            chk("flush",       i, {31'b0, flush}, {31'b0, vecs[i].e_flush});
            chk("pcsrc",       i, {30'b0, src},   {30'b0, vecs[i].e_src});
        end

        // Asynchronous reset in the middle of a cycle, then confirm the BTB was wiped.
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        chk("pc_before_reset", 100, pc, 32'h84);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("pc_async_reset", 101, pc, 32'h0);
        chk("pred_async_reset", 101, {31'b0, ptk}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        eret = 1'b1;
        epc = 32'h20;
        #1;
        n_vec++;
        chk("pc_after_release", 102, pc, 32'h0);
        chk("pcsrc_after_release", 102, {30'b0, src}, 32'h2);
        @(negedge clk);
        idle();
        #1;
        n_vec++;
        chk("pc_redirect_after_reset", 103, pc, 32'h20);
        chk("btb_cleared", 103, {31'b0, ptk}, 32'h0);
        chk("flush_after_reset", 103, {31'b0, flush}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
